// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among N_REQ requesters.
// Each grant is held for up to MAX_BURST words so a requester's data stays contiguous.
module fifo_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                          wfull,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              ack,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [OW-1:0]       owner_reg, owner_next;
    logic [OW-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [BW-1:0]       burst_cnt_reg, burst_cnt_next;
    logic [N_REQ-1:0]    gnt_reg, gnt_next;

    logic [OW-1:0]       owner_inc;
    logic [OW-1:0]       pick_start;
    logic [OW-1:0]       pick_idx;
    logic                pick_found;
    logic [N_REQ-1:0]    pick_onehot;
    logic                owner_req;
    logic                burst_last;
    logic                release_now;
    logic                we;

    logic [DATA_WIDTH-1:0] masked_data [N_REQ];

    // gnt_reg is kept equal to onehot(owner) in GRANT and zero in IDLE, so it
    // doubles as the data-mux select and makes every output zero in IDLE.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign masked_data[gi] = gnt_reg[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                                 : '0;
            assign pick_onehot[gi] = (pick_idx == OW'(gi));
        end
    endgenerate

    always_comb begin
        wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            wdata = wdata | masked_data[k];
        end
    end

    assign owner_req    = |(req & gnt_reg);
    assign we           = owner_req & ~wfull;
    assign write_enable = we;
    assign ack          = we ? gnt_reg : '0;
    assign gnt          = gnt_reg;
    assign busy         = (state_reg == GRANT);

    assign owner_inc   = (owner_reg == OW'(N_REQ - 1)) ? '0 : owner_reg + OW'(1);
    assign burst_last  = (burst_cnt_reg == BW'(MAX_BURST - 1));
    assign release_now = (state_reg == GRANT) && ((we && burst_last) || !owner_req);
    assign pick_start  = (state_reg == GRANT) ? owner_inc : rr_ptr_reg;

    // Search pick_start, pick_start+1, ... modulo N_REQ; iterating downward
    // leaves the closest hit to pick_start as the final assignment.
    always_comb begin
        logic [OW:0]   sum;
        logic [OW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, pick_start} + (OW+1)'(k);
            if (sum >= (OW+1)'(N_REQ)) begin
                sum = sum - (OW+1)'(N_REQ);
            end
            cand = sum[OW-1:0];
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt_next       = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    owner_next     = pick_idx;
                    burst_cnt_next = '0;
                    gnt_next       = pick_onehot;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_next    = owner_inc;
                    burst_cnt_next = '0;
                    if (pick_found) begin
                        owner_next = pick_idx;
                        gnt_next   = pick_onehot;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end else if (we) begin
                    burst_cnt_next = burst_cnt_reg + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            gnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            gnt_reg       <= gnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter, including a small write_gray_counter
// model (16-deep FIFO, wqr held at zero) for the full-flag integration check.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        write_enable;
    logic [7:0]  wdata;
    logic        busy;

    logic        wfull_drv;
    logic        use_model;
    logic [4:0]  m_bin;
    logic [4:0]  m_gry;
    logic        m_wfull;
    logic [4:0]  m_bin_nx;
    logic [4:0]  m_gry_nx;

    int checks   = 0;
    int failures = 0;

    fifo_write_arbiter #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .wfull        (wfull),
        .gnt          (gnt),
        .ack          (ack),
        .write_enable (write_enable),
        .wdata        (wdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write_gray_counter model: full when next Gray equals inverted-MSBs wqr (0).
    assign m_bin_nx = m_bin + {4'b0, write_enable};
    assign m_gry_nx = m_bin_nx ^ (m_bin_nx >> 1);
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bin   <= 5'd0;
            m_gry   <= 5'd0;
            m_wfull <= 1'b0;
        end else begin
            m_bin   <= m_bin_nx;
            m_gry   <= m_gry_nx;
            m_wfull <= (m_gry_nx == 5'b11000);
        end
    end

    assign wfull = use_model ? m_wfull : wfull_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack != 4'b0)
            $display("t=%0t ack=%b wdata=%h gnt=%b", $time, ack, wdata, gnt);
    endtask

    task automatic pulse_reset(input logic [3:0] new_req);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req = new_req;
        #1;
    endtask

    int          order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  e_oh;

    initial begin
        rst       = 1'b0;
        req       = 4'b0000;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        wfull_drv = 1'b0;
        use_model = 1'b0;
        #2;
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_we",    32'(write_enable), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        tick();

        // Fairness: all four requesting, grant order 0,1,2,3,0 with 4 acks each.
        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("idle_we", 32'(write_enable), 32'h0);
        tick();
        for (int b = 0; b < 5; b++) begin
            e_oh = 4'b0001 << order[b];
            for (int w = 0; w < 4; w++) begin
                chk("fair_gnt",   32'(gnt), 32'(e_oh));
                chk("fair_ack",   32'(ack), 32'(e_oh));
                chk("fair_wdata", 32'(wdata), 32'(8'hA0 + order[b]));
                tick();
            end
        end

        // Reset mid-burst (owner 1 active): outputs clear without a clock edge.
        chk("mid_gnt_pre", 32'(gnt), 32'h2);
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt",  32'(gnt), 32'h0);
        chk("mid_rst_ack",  32'(ack), 32'h0);
        chk("mid_rst_we",   32'(write_enable), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);

        // Single requester: continuous writes across burst boundaries.
        pulse_reset(4'b0010);
        tick();
        for (int c = 0; c < 12; c++) begin
            chk("single_gnt", 32'(gnt), 32'h2);
            chk("single_we",  32'(write_enable), 32'h1);
            chk("single_ack", 32'(ack), 32'h2);
            tick();
        end

        // Stall: requester 2 owns, wfull for 3 cycles after its 2nd word.
        pulse_reset(4'b1100);
        tick();
        chk("stall_w1", 32'(ack), 32'h4);
        tick();
        chk("stall_w2", 32'(ack), 32'h4);
        tick();
        wfull_drv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_we",  32'(write_enable), 32'h0);
            chk("stall_ack", 32'(ack), 32'h0);
            chk("stall_gnt", 32'(gnt), 32'h4);
            tick();
        end
        wfull_drv = 1'b0;
        #1;
        chk("stall_w3", 32'(ack), 32'h4);
        tick();
        chk("stall_w4", 32'(ack), 32'h4);
        tick();
        chk("stall_next_gnt", 32'(gnt), 32'h8);
        chk("stall_next_ack", 32'(ack), 32'h8);

        // Early drop: requester 0 drops after 2 acks, requester 3 waiting.
        pulse_reset(4'b1001);
        tick();
        chk("drop_w1", 32'(ack), 32'h1);
        tick();
        chk("drop_w2", 32'(ack), 32'h1);
        tick();
        req = 4'b1000;
        #1;
        chk("drop_we",  32'(write_enable), 32'h0);
        chk("drop_ack", 32'(ack), 32'h0);
        chk("drop_gnt", 32'(gnt), 32'h1);
        tick();
        chk("drop_new_gnt", 32'(gnt), 32'h8);
        chk("drop_new_ack", 32'(ack), 32'h8);
        chk("drop_wdata",   32'(wdata), 32'hA3);

        // Integration with the counter model: exactly 16 words then full.
        use_model = 1'b1;
        pulse_reset(4'b0001);
        tick();
        for (int c = 0; c < 16; c++) begin
            chk("int_wfull_low", 32'(wfull), 32'h0);
            chk("int_ack", 32'(ack), 32'h1);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            chk("int_wfull", 32'(wfull), 32'h1);
            chk("int_we",    32'(write_enable), 32'h0);
            chk("int_gry",   32'(m_gry), 32'h18);
            chk("int_gnt",   32'(gnt), 32'h1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing the single write port of the asynchronous FIFO among `N_REQ` write-domain requesters. It sits in the write clock domain directly in front of `write_gray_counter`. It drives that counter's `write_enable` and the FIFO memory write data, and gates writes with the counter's registered `wfull`. Each grant is held for a burst of up to `MAX_BURST` words, so a requester's data stays contiguous in the FIFO.

## Interface
Parameters:
- `N_REQ`, default 4, number of requesters (2..16).
- `DATA_WIDTH`, default 8, FIFO word width.
- `MAX_BURST`, default 4, maximum words written per grant (at least 1).

Ports:
- `clk`  in  1  write-domain clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `req`  in  N_REQ  per-requester data-valid; held high while `req_data` slice is valid.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wfull`  in  1  full flag from `write_gray_counter`.
- `gnt`  out  N_REQ  one-hot current owner, registered; all zero when idle.
- `ack`  out  N_REQ  one-hot; `ack[i]`=1 means requester i's word is written at this edge.
- `write_enable`  out  1  to `write_gray_counter.write_enable` and FIFO memory write strobe.
- `wdata`  out  DATA_WIDTH  owner's `req_data` slice; 0 when idle.
- `busy`  out  1  state is GRANT.

## Operation
State registers:
- `state`: IDLE or GRANT.
- `owner`: `$clog2(N_REQ)` bits.
- `rr_ptr`: highest-priority index, same width as `owner`.
- `burst_cnt`: `$clog2(MAX_BURST+1)` bits.

Round-robin pick, from a start index s:
- Select the first i with `req[i]`=1, searching s, s+1, …, wrapping modulo `N_REQ`.

IDLE:
- If any `req` bit is set: pick from `rr_ptr`, load `owner`, clear `burst_cnt`, go to GRANT.
- Otherwise stay in IDLE.
- No writes occur in IDLE.

GRANT:
- `write_enable` = `req[owner]` & ~`wfull` (combinational).
- `ack` = onehot(`owner`) when `write_enable`=1, else 0.
- `wdata` = `req_data` slice of `owner`.
- Each cycle with `write_enable`=1, `burst_cnt` increments.

Release from GRANT, at the edge where either condition holds:
- (a) `write_enable`=1 and `burst_cnt`==`MAX_BURST`-1. The final word is written at this edge.
- (b) `req[owner]`=0. No write occurs that cycle.

On release:
- `rr_ptr` ← (`owner`+1) mod `N_REQ`.
- Re-pick from that value using the current `req`. The old owner has lowest priority but can win if it is the only requester.
- If a requester is found: stay in GRANT with the new `owner` and `burst_cnt`=0. Otherwise go to IDLE.

Full handling:
- While `wfull`=1 in GRANT: no write, no ack, `burst_cnt` holds, `owner` holds.
- Full alone never releases the grant.
- Because `wfull` is registered from the next Gray value, the write that fills the FIFO is the last one accepted. No overrun and no dropped word.

Other rules:
- The requester must hold `req` and `req_data` stable until it sees `ack`. Dropping `req` abandons the rest of the burst.
- `gnt` changes only at edges; it is never zero while `busy`=1.

## Timing
Reset (`rst`=0, asynchronous):
- State is IDLE; `owner`, `rr_ptr` and `burst_cnt` are 0.
- `gnt`=0, `busy`=0, so `write_enable`=0, `ack`=0 and `wdata`=0 immediately, without waiting for a clock edge.
- Reset mid-burst discards the burst. Words already acked remain in the FIFO.

Arbitration latency:
- `req` rising in IDLE at cycle t → `gnt` set after edge t. The first write is in cycle t+1, at edge t+1.

Back-to-back bursts:
- Owner change at a release edge costs no bubble when the next requester is already asserted.

Throughput:
- One word per cycle while owner `req`=1 and `wfull`=0.

## Test plan
- Reset: drive `rst`=0 during a burst → `gnt`, `ack` and `write_enable` are 0 within the same cycle. After `rst`=1 with `req`=4'b1111, the first grant is `gnt`=4'b0001.
- Single requester: `req`=4'b0010 held → `gnt`=4'b0010 from the next edge, with continuous `write_enable`. `burst_cnt` wraps every 4 writes and `gnt` stays 4'b0010 with no idle cycle.
- Fairness: `req`=4'b1111 held, FIFO drained → grant order 0,1,2,3,0, with exactly 4 acks each and no gap between bursts.
- Stall: assert `wfull` for 3 cycles after the 2nd word of requester 2's burst → `write_enable`=0 and `ack`=0 for 3 cycles, `gnt` held. Then 2 more words, then release.
- Early drop: requester 0 drops `req` after 2 acks while `req[3]`=1 → one no-write cycle, then `gnt`=4'b1000 at the next edge.
- Integration with `write_gray_counter`, with `wqr` held 5'b00000 and `req`=4'b0001: exactly 16 words are acked. After the 16th edge `wfull`=1, `write_enable` stays 0 and the counter's `gry` stays 5'b11000.
